// File: rtl/jogo_pkg.sv
// Shared definitions for the ultimate tic-tac-toe datapath: cell codes,
// checker state encoding and the scan-ordered table of the eight 3x3 lines.
package jogo_pkg;

  localparam int NUM_CELULAS = 9;

  localparam logic [1:0] VAZIO   = 2'b00;
  localparam logic [1:0] X       = 2'b01;
  localparam logic [1:0] O       = 2'b10;
  localparam logic [1:0] FECHADO = 2'b11;

  // Board index that selects the macro board-state image instead of a micro board
  localparam logic [3:0] IDX_MACRO = 4'd9;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LEITURA = 3'd1,
    AVALIA  = 3'd2,
    FIM     = 3'd3
  } estado_t;

  // Rows, then columns, then diagonals; scan order decides winner priority
  localparam logic [3:0] LINHAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/linha_vencida.sv
// Combinational single-line judge: three equal X or O cells win.
// A closed cell (11) never wins even when all three match.
import jogo_pkg::*;

module linha_vencida (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic [1:0] i_c,
  output logic       o_vence,
  output logic [1:0] o_codigo
);

  assign o_vence  = (i_a == i_b) && (i_b == i_c) && ((i_a == X) || (i_a == O));
  assign o_codigo = o_vence ? i_a : VAZIO;

endmodule

// File: rtl/verificador_tabuleiro.sv
// Sequential 3x3 win/draw checker: streams nine cells out of a synchronous RAM,
// scans one line per cycle and pulses pronto with registered results.
import jogo_pkg::*;

module verificador_tabuleiro (
  input  logic       clock,
  input  logic       reset,
  input  logic       verificar,
  input  logic [3:0] tabuleiro,
  input  logic [1:0] dado_celula,
  output logic [7:0] endereco,
  output logic       ocupado,
  output logic       pronto,
  output logic       tem_vencedor,
  output logic [1:0] vencedor,
  output logic       empate,
  output logic [2:0] db_estado
);

  estado_t                      r_estado, w_estado_prox;
  logic [3:0]                   r_tab, w_tab_prox;
  logic [3:0]                   r_celula, w_celula_prox;
  logic [2:0]                   r_linha;
  logic [NUM_CELULAS-1:0][1:0]  r_celulas;
  logic [7:0]                   w_endereco_prox;
  logic [1:0]                   w_a, w_b, w_c, w_codigo;
  logic                         w_vence, w_sem_vazio;

  assign w_a = r_celulas[LINHAS[r_linha][0]];
  assign w_b = r_celulas[LINHAS[r_linha][1]];
  assign w_c = r_celulas[LINHAS[r_linha][2]];

  linha_vencida u_linha (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_c      (w_c),
    .o_vence  (w_vence),
    .o_codigo (w_codigo)
  );

  always_comb begin
    w_sem_vazio = 1'b1;
    for (int k = 0; k < NUM_CELULAS; k++)
      if (r_celulas[k] == VAZIO) w_sem_vazio = 1'b0;
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_tab_prox    = r_tab;
    w_celula_prox = r_celula;
    case (r_estado)
      OCIOSO: if (verificar) begin
        w_estado_prox = LEITURA;
        w_tab_prox    = tabuleiro;
        w_celula_prox = 4'd0;
      end
      // celula runs to 9 so the read of cell 8 lands before leaving
      LEITURA: if (r_celula == 4'd9) w_estado_prox = AVALIA;
               else                  w_celula_prox = r_celula + 4'd1;
      AVALIA:  if (r_linha == 3'd7)  w_estado_prox = FIM;
      FIM:     w_estado_prox = OCIOSO;
      default: w_estado_prox = OCIOSO;
    endcase
    w_endereco_prox = {w_tab_prox, (w_estado_prox == LEITURA) ? w_celula_prox : 4'd0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado     <= OCIOSO;
      r_tab        <= 4'd0;
      r_celula     <= 4'd0;
      r_linha      <= 3'd0;
      r_celulas    <= '0;
      endereco     <= 8'd0;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
      tem_vencedor <= 1'b0;
      vencedor     <= VAZIO;
      empate       <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      r_tab    <= w_tab_prox;
      r_celula <= w_celula_prox;
      endereco <= w_endereco_prox;
      ocupado  <= (w_estado_prox != OCIOSO);
      pronto   <= (w_estado_prox == FIM);
      case (r_estado)
        OCIOSO: if (verificar) begin
          r_celulas    <= '0;
          r_linha      <= 3'd0;
          tem_vencedor <= 1'b0;
          vencedor     <= VAZIO;
          empate       <= 1'b0;
        end
        LEITURA: if (r_celula != 4'd0) r_celulas[r_celula - 4'd1] <= dado_celula;
        AVALIA: begin
          r_linha <= r_linha + 3'd1;
          // first winning line in scan order sticks
          if (w_vence && !tem_vencedor) begin
            tem_vencedor <= 1'b1;
            vencedor     <= w_codigo;
          end
          if (r_linha == 3'd7)
            empate <= !(tem_vencedor || w_vence) && w_sem_vazio;
        end
        default: ;
      endcase
    end
  end

  assign db_estado = r_estado;

endmodule

// File: tb/tb_verificador_tabuleiro.sv
// Directed bench for verificador_tabuleiro with a synchronous-read RAM model;
// expected results are hand-derived per board.
module tb_verificador_tabuleiro;

  localparam logic [1:0] CV = 2'b00, CX = 2'b01, CO = 2'b10, CF = 2'b11;

  logic       clock = 1'b0;
  logic       reset, verificar;
  logic [3:0] tabuleiro;
  logic [1:0] dado_celula;
  logic [7:0] endereco;
  logic       ocupado, pronto, tem_vencedor, empate;
  logic [1:0] vencedor;
  logic [2:0] db_estado;

  logic [1:0] mem [256];
  int vetores = 0;
  int erros   = 0;

  verificador_tabuleiro dut (
    .clock        (clock),
    .reset        (reset),
    .verificar    (verificar),
    .tabuleiro    (tabuleiro),
    .dado_celula  (dado_celula),
    .endereco     (endereco),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .tem_vencedor (tem_vencedor),
    .vencedor     (vencedor),
    .empate       (empate),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) dado_celula <= mem[endereco];

  task automatic carrega(input logic [3:0] tab, input logic [8:0][1:0] cel);
    for (int k = 0; k < 9; k++) mem[{tab, 4'(k)}] = cel[k];
  endtask

  // Leaves the bench at the negedge of cycle T+1
  task automatic dispara(input logic [3:0] tab);
    @(negedge clock);
    verificar = 1'b1;
    tabuleiro = tab;
    @(negedge clock);
    verificar = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; verificar = 1'b0; tabuleiro = 4'd0;
    repeat (2) @(negedge clock);
    vetores++; if (endereco !== 8'd0)     begin erros++; $display("FAIL reset endereco: got %h exp 00", endereco); end
    vetores++; if (ocupado !== 1'b0)      begin erros++; $display("FAIL reset ocupado: got %b exp 0", ocupado); end
    vetores++; if (pronto !== 1'b0)       begin erros++; $display("FAIL reset pronto: got %b exp 0", pronto); end
    vetores++; if (tem_vencedor !== 1'b0) begin erros++; $display("FAIL reset tem_vencedor: got %b exp 0", tem_vencedor); end
    vetores++; if (vencedor !== 2'b00)    begin erros++; $display("FAIL reset vencedor: got %b exp 00", vencedor); end
    vetores++; if (empate !== 1'b0)       begin erros++; $display("FAIL reset empate: got %b exp 0", empate); end
    vetores++; if (db_estado !== 3'd0)    begin erros++; $display("FAIL reset db_estado: got %0d exp 0", db_estado); end
    // reset and verificar on the same edge: reset wins
    verificar = 1'b1; tabuleiro = 4'd4;
    @(negedge clock);
    vetores++; if (ocupado !== 1'b0)   begin erros++; $display("FAIL reset_vs_start ocupado: got %b exp 0", ocupado); end
    vetores++; if (db_estado !== 3'd0) begin erros++; $display("FAIL reset_vs_start db_estado: got %0d exp 0", db_estado); end
    reset = 1'b0; verificar = 1'b0;
    @(negedge clock);
    vetores++; if (ocupado !== 1'b0) begin erros++; $display("FAIL reset_vs_start later ocupado: got %b exp 0", ocupado); end
  endtask

  task automatic test_tabuleiro(input string nome, input logic [3:0] tab, input logic [8:0][1:0] cel,
                                input logic et, input logic [1:0] ev, input logic ee);
    carrega(tab, cel);
    dispara(tab);
    for (int j = 1; j <= 20; j++) begin
      if (j <= 9) begin
        vetores++;
        if (endereco !== {tab, 4'(j-1)})
          begin erros++; $display("FAIL %s endereco c%0d: got %h exp %h", nome, j, endereco, {tab, 4'(j-1)}); end
      end
      vetores++;
      if (ocupado !== (j <= 19)) begin erros++; $display("FAIL %s ocupado c%0d: got %b exp %b", nome, j, ocupado, (j <= 19)); end
      vetores++;
      if (pronto !== (j == 19)) begin erros++; $display("FAIL %s pronto c%0d: got %b exp %b", nome, j, pronto, (j == 19)); end
      if (j == 1) begin
        vetores++;
        if ({tem_vencedor, vencedor, empate} !== 4'b0000 || db_estado !== 3'd1)
          begin erros++; $display("FAIL %s start clear: got t%b v%b e%b s%0d exp t0 v00 e0 s1", nome, tem_vencedor, vencedor, empate, db_estado); end
      end
      if (j == 11) begin
        vetores++;
        if (db_estado !== 3'd2) begin erros++; $display("FAIL %s db_estado c11: got %0d exp 2", nome, db_estado); end
      end
      if (j == 19 || j == 20) begin
        vetores++;
        if (tem_vencedor !== et) begin erros++; $display("FAIL %s tem_vencedor c%0d: got %b exp %b", nome, j, tem_vencedor, et); end
        vetores++;
        if (vencedor !== ev) begin erros++; $display("FAIL %s vencedor c%0d: got %b exp %b", nome, j, vencedor, ev); end
        vetores++;
        if (empate !== ee) begin erros++; $display("FAIL %s empate c%0d: got %b exp %b", nome, j, empate, ee); end
        vetores++;
        if (db_estado !== ((j == 19) ? 3'd3 : 3'd0))
          begin erros++; $display("FAIL %s db_estado c%0d: got %0d", nome, j, db_estado); end
      end
      if (j < 20) @(negedge clock);
    end
  endtask

  task automatic test_ignora_verificar;
    int np = 0;
    int ciclo = 0;
    carrega(4'd3, {CV,CV,CV,CV,CO,CO,CX,CX,CX});
    dispara(4'd3);
    for (int j = 1; j <= 45; j++) begin
      if (j == 5) begin verificar = 1'b1; tabuleiro = 4'd7; end
      if (j == 6) verificar = 1'b0;
      if (j == 7) begin
        vetores++;
        if (endereco !== 8'h36) begin erros++; $display("FAIL ignore endereco c7: got %h exp 36", endereco); end
      end
      if (pronto === 1'b1) begin np++; ciclo = j; end
      @(negedge clock);
    end
    vetores++;
    if (np != 1 || ciclo != 19) begin erros++; $display("FAIL ignore pronto: got %0d pulses last c%0d exp 1 at c19", np, ciclo); end
    vetores++;
    if (vencedor !== CX) begin erros++; $display("FAIL ignore vencedor: got %b exp 01", vencedor); end
  endtask

  task automatic test_reset_meio;
    int np = 0;
    carrega(4'd4, {CV,CV,CV,CV,CO,CO,CX,CX,CX});
    dispara(4'd4);
    repeat (11) @(negedge clock);  // cycle T+12
    vetores++;
    if (tem_vencedor !== 1'b1) begin erros++; $display("FAIL abort pre tem_vencedor: got %b exp 1", tem_vencedor); end
    reset = 1'b1;
    @(negedge clock);              // cycle T+13
    vetores++;
    if ({endereco, ocupado, pronto, tem_vencedor, vencedor, empate, db_estado} !== 17'd0)
      begin erros++; $display("FAIL abort outputs: got a%h o%b p%b t%b v%b e%b s%0d exp all 0", endereco, ocupado, pronto, tem_vencedor, vencedor, empate, db_estado); end
    reset = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clock);
      if (pronto === 1'b1 || ocupado === 1'b1) np++;
    end
    vetores++;
    if (np != 0) begin erros++; $display("FAIL abort activity: got %0d busy/pronto cycles exp 0", np); end
  endtask

  task automatic test_back_to_back;
    carrega(4'd1, {CV,CV,CV,CV,CO,CO,CX,CX,CX});
    carrega(4'd6, {CX,CX,CO,CO,CO,CX,CX,CO,CX});
    dispara(4'd1);
    repeat (18) @(negedge clock);  // cycle T+19
    vetores++;
    if (pronto !== 1'b1 || tem_vencedor !== 1'b1)
      begin erros++; $display("FAIL b2b first: got p%b t%b exp p1 t1", pronto, tem_vencedor); end
    @(negedge clock);
    verificar = 1'b1; tabuleiro = 4'd6;
    @(negedge clock);              // cycle T'+1
    verificar = 1'b0;
    vetores++;
    if (ocupado !== 1'b1 || tem_vencedor !== 1'b0 || vencedor !== 2'b00 || endereco !== 8'h60)
      begin erros++; $display("FAIL b2b accept: got o%b t%b v%b a%h exp o1 t0 v00 a60", ocupado, tem_vencedor, vencedor, endereco); end
    repeat (17) @(negedge clock);  // cycle T'+18
    vetores++;
    if (pronto !== 1'b0) begin erros++; $display("FAIL b2b early pronto: got %b exp 0", pronto); end
    @(negedge clock);              // cycle T'+19
    vetores++;
    if (pronto !== 1'b1 || tem_vencedor !== 1'b0 || empate !== 1'b1)
      begin erros++; $display("FAIL b2b second: got p%b t%b e%b exp p1 t0 e1", pronto, tem_vencedor, empate); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = CV;
    reset = 1'b1; verificar = 1'b0; tabuleiro = 4'd0;
    test_reset;
    test_tabuleiro("row0_x",    4'd2,  {CV,CV,CV,CV,CO,CO,CX,CX,CX}, 1'b1, CX, 1'b0);
    test_tabuleiro("diag_o",    4'd5,  {CX,CV,CO,CV,CO,CV,CO,CV,CX}, 1'b1, CO, 1'b0);
    test_tabuleiro("row_col_x", 4'd0,  {CV,CO,CX,CO,CO,CX,CX,CX,CX}, 1'b1, CX, 1'b0);
    test_tabuleiro("prio_row0", 4'd8,  {CO,CO,CO,CV,CV,CV,CX,CX,CX}, 1'b1, CX, 1'b0);
    test_tabuleiro("full_draw", 4'd7,  {CX,CX,CO,CO,CO,CX,CX,CO,CX}, 1'b0, CV, 1'b1);
    test_tabuleiro("one_empty", 4'd7,  {CV,CX,CO,CO,CO,CX,CX,CO,CX}, 1'b0, CV, 1'b0);
    test_tabuleiro("closed",    4'd9,  {CO,CX,CO,CX,CO,CX,CF,CF,CF}, 1'b0, CV, 1'b1);
    test_tabuleiro("idx12_col", 4'd12, {CO,CV,CV,CO,CV,CV,CO,CV,CV}, 1'b1, CO, 1'b0);
    test_ignora_verificar;
    test_reset_meio;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/verificador_tabuleiro.md
# verificador_tabuleiro

Sequential 3×3 win checker for the ultimate tic-tac-toe datapath. On a single-cycle `verificar` request it reads the nine cells of one board (a micro board or the macro board-state image) from a synchronous-read RAM and scans the eight lines. It then reports winner or draw with a one-cycle `pronto` pulse. Its registered results drive the control unit's `macro_vencida` and `fim_jogo` decisions after `registra_jogada` / `registra_resultado`.

## Interface
- `NUM_CELULAS`, 9: cells per board; fixed, not intended to be overridden.
- `clock`  in  1  single system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clock`.
- `verificar`  in  1  start request; sampled only in OCIOSO.
- `tabuleiro`  in  4  board index 0–8; 9 selects macro board-state image; captured at start.
- `dado_celula`  in  2  RAM read data for the address presented on the previous cycle.
- `endereco`  out  8  RAM read address = {tabuleiro_reg[3:0], celula[3:0]}.
- `ocupado`  out  1  high from the cycle after start until `pronto` inclusive.
- `pronto`  out  1  one-cycle completion pulse.
- `tem_vencedor`  out  1  a line of three equal X or O cells exists.
- `vencedor`  out  2  01 = X, 10 = O, 00 = none.
- `empate`  out  1  no winner and all nine cells non-empty.
- `db_estado`  out  3  current state encoding, for 7-segment debug.

## Operation
- Cell codes: 00 empty, 01 X, 10 O, 11 closed (drawn micro board). 11 never forms a line but counts as occupied.
- States: OCIOSO(0) → LEITURA(1) → AVALIA(2) → FIM(3) → OCIOSO.
- OCIOSO: `verificar`=1 captures `tabuleiro`, clears cell register, line counter, and all results; next state LEITURA.
- LEITURA: `celula` counts 0..8; `dado_celula` captured one cycle after each address into cell register slot (`celula`−1). It stays in LEITURA until slot 8 is captured.
- AVALIA: one line per cycle, in order: rows {0,1,2},{3,4,5},{6,7,8}; cols {0,3,6},{1,4,7},{2,5,8}; diags {0,4,8},{2,4,6}.
  - A line wins if its three cells are equal and ∈{01,10}.
  - The first winning line in scan order sets `vencedor` and `tem_vencedor`; later lines never overwrite them.
  - Always scans all 8 lines; latency is fixed.
- FIM: `empate` = !tem_vencedor && no cell == 00; `pronto`=1; next OCIOSO.
- Results hold their value until the next accepted start or reset.
- `verificar` outside OCIOSO is ignored, with no queuing.
- `tabuleiro` values 10–15 are checked like any other index; the address is simply formed from them.
- `endereco` = {tabuleiro_reg, 4'd0} whenever not in LEITURA.

## Timing
- Start sampled at edge T (in OCIOSO).
- Addresses cell 0..8 presented during cycles T+1..T+9.
- Cell k captured at edge T+2+k; the last capture is at T+10.
- AVALIA cycles T+11..T+18.
- FIM at T+19: `pronto`=1 and final results valid in the same cycle.
- Total latency is 19 cycles from start edge to `pronto`. A new start is accepted at the earliest in the cycle after `pronto`.
- `ocupado` is high for cycles T+1..T+19.
- Reset values: state OCIOSO, `endereco`=0, `ocupado`=0, `pronto`=0, `tem_vencedor`=0, `vencedor`=00, `empate`=0, `db_estado`=0.
- Reset mid-operation aborts immediately: no `pronto`, results cleared.
- Reset and `verificar` high on the same edge: reset wins and no start occurs.

## Structure
- Shared package `jogo_pkg`:
  - cell code constants (VAZIO, X, O, FECHADO)
  - state encoding
  - `LINHAS`: 8×3 constant table of cell indices in scan order
  - `IDX_MACRO` = 9
- One natural sub-module, `linha_vencida`: combinational; takes 3 cells and returns win flag plus winner code. It is instantiated once and fed by a mux indexed by the line counter.
- All outputs are registered.

## Test plan
- X on cells 0,1,2, O on 3,4, rest empty, `tabuleiro`=2 → `endereco` 0x20..0x28 at T+1..T+9; `pronto` at T+19; `vencedor`=01, `tem_vencedor`=1, `empate`=0.
- O on diagonal 2,4,6 plus X on 0 and 8 → `vencedor`=10 at T+19. X on both row 0 and column 0 → `vencedor`=01, with the row-0 line taking priority.
- Full board X O X / X O O / O X X → `tem_vencedor`=0, `empate`=1. The same board with cell 8 = 00 → `empate`=0.
- Cells 0,1,2 = 11 (closed) and the rest filled with no line → no winner, `empate`=1. `tabuleiro`=9 → addresses 0x90..0x98.
- `verificar` pulsed again at T+5 → ignored, single `pronto` at T+19. Reset asserted at T+12 → outputs at reset values at T+13 and no `pronto` follows.
- Back-to-back: second `verificar` in the cycle after `pronto` → accepted; results cleared at the start, and the new `pronto` arrives 19 cycles later.
